// File: rtl/fifo_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_if
//
// Groups the write-side signals of an asynchronous FIFO write controller.
//
//   wr_en        producer write request
//   rq_wptr_sync Gray read pointer, already synchronised into the write clock
//   ovf_clr      clears the sticky overflow flag
//   waddr        memory write address
//   wclken       memory write enable (combinational)
//   wptr         registered Gray write pointer, to the read-side synchroniser
//   wfull        registered full flag
//   walmost_full registered almost-full flag
//   wlevel       registered fill level, 0..DEPTH
//   woverflow    sticky "write attempted while full" flag
//
// Modports:
//   master  the write controller (consumes requests, produces status)
//   slave   the producer / surrounding logic
// -----------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
  parameter int ADDR_BITS = 8
);
  localparam int PTR_W = ADDR_BITS + 1;

  logic               wr_en;
  logic [PTR_W-1:0]   rq_wptr_sync;
  logic               ovf_clr;
  logic [ADDR_BITS-1:0] waddr;
  logic               wclken;
  logic [PTR_W-1:0]   wptr;
  logic               wfull;
  logic               walmost_full;
  logic [PTR_W-1:0]   wlevel;
  logic               woverflow;

  modport master (
    input  wr_en,
    input  rq_wptr_sync,
    input  ovf_clr,
    output waddr,
    output wclken,
    output wptr,
    output wfull,
    output walmost_full,
    output wlevel,
    output woverflow
  );

  modport slave (
    output wr_en,
    output rq_wptr_sync,
    output ovf_clr,
    input  waddr,
    input  wclken,
    input  wptr,
    input  wfull,
    input  walmost_full,
    input  wlevel,
    input  woverflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side controller of an asynchronous (dual-clock) FIFO. Keeps the binary
// and Gray write pointers, generates the memory write strobe/address and
// derives full, almost-full, fill level and a sticky overflow flag from the
// synchronised Gray read pointer.
//
// Ports:
//   clk  write-domain clock
//   rst  asynchronous reset, active low
//   bus  fifo_wr_ctrl_if.master (see interface header for signal list)
//
// Parameters:
//   ADDR_BITS     memory address width; DEPTH = 2**ADDR_BITS (>= 2)
//   AFULL_THRESH  almost-full margin in entries, 1..DEPTH-1
//
// Every status output is registered, so rq_wptr_sync never reaches an
// output combinationally; only wclken depends combinationally on wr_en.
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
  parameter int ADDR_BITS    = 8,
  parameter int AFULL_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_ctrl_if.master    bus
);

  localparam int PTR_W = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL_THRESH);

  // Registered state
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wgray;
  logic             full_q;
  logic             afull_q;
  logic [PTR_W-1:0] level_q;
  logic             ovf_q;

  // Next-state values
  logic             accept;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rq_full_cmp;
  logic [PTR_W-1:0] level_next;
  logic             full_next;
  logic             afull_next;
  logic             ovf_next;

  // A write is taken only while not full; a blocked write never touches
  // memory or the pointers.
  assign accept = bus.wr_en & ~full_q;

  // NOTE: every always_comb output gets a default assignment first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wbin_next  = '0;
    wgray_next = '0;
    wbin_next  = wbin + PTR_W'(accept);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
  end

  // Gray -> binary: bit i of the binary value is the XOR of all Gray bits
  // from the MSB down to bit i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_W; i++) begin
      rbin[i] = ^(bus.rq_wptr_sync >> i);
    end
  end

  // The write pointer is exactly DEPTH ahead of the read pointer when the two
  // top Gray bits differ and the rest match.
  always_comb begin
    rq_full_cmp = bus.rq_wptr_sync;
    rq_full_cmp[PTR_W-1] = ~bus.rq_wptr_sync[PTR_W-1];
    rq_full_cmp[PTR_W-2] = ~bus.rq_wptr_sync[PTR_W-2];
  end

  always_comb begin
    level_next = wbin_next - rbin;
    full_next  = (wgray_next == rq_full_cmp);
    afull_next = (level_next >= AFULL_LEVEL);
    // Set has priority over clear so an overflow coinciding with a clear
    // request is never lost.
    ovf_next   = (bus.wr_en & full_q) | (ovf_q & ~bus.ovf_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= full_next;
      afull_q <= afull_next;
      level_q <= level_next;
      ovf_q   <= ovf_next;
    end
  end

  assign bus.wclken       = accept;
  assign bus.waddr        = wbin[ADDR_BITS-1:0];
  assign bus.wptr         = wgray;
  assign bus.wfull        = full_q;
  assign bus.walmost_full = afull_q;
  assign bus.wlevel       = level_q;
  assign bus.woverflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Directed testbench for fifo_wr_ctrl with ADDR_BITS=3 (DEPTH=8) and
// AFULL_THRESH=2. Inputs change 1 time unit after a rising edge; registered
// outputs are sampled at that same point, combinational outputs 1 unit later.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  localparam int ADDR_BITS = 3;
  localparam int PTR_W     = ADDR_BITS + 1;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  fifo_wr_ctrl_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  fifo_wr_ctrl #(
    .ADDR_BITS    (ADDR_BITS),
    .AFULL_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance one clock and land 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gray read pointers for reads 1..8 and the Gray write pointer after the
  // refill write that follows each read (binary 9..15, then 0).
  logic [PTR_W-1:0] rd_gray [1:8];
  logic [PTR_W-1:0] wr_gray [1:8];

  initial begin
    rd_gray[1] = 4'b0001; rd_gray[2] = 4'b0011; rd_gray[3] = 4'b0010;
    rd_gray[4] = 4'b0110; rd_gray[5] = 4'b0111; rd_gray[6] = 4'b0101;
    rd_gray[7] = 4'b0100; rd_gray[8] = 4'b1100;
    wr_gray[1] = 4'b1101; wr_gray[2] = 4'b1111; wr_gray[3] = 4'b1110;
    wr_gray[4] = 4'b1010; wr_gray[5] = 4'b1011; wr_gray[6] = 4'b1001;
    wr_gray[7] = 4'b1000; wr_gray[8] = 4'b0000;

    n_checks = 0;
    n_pass   = 0;
    rst              = 1'b0;
    bus.wr_en        = 1'b0;
    bus.rq_wptr_sync = '0;
    bus.ovf_clr      = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_wptr",  bus.wptr, 0);
    check("rst_wlevel", bus.wlevel, 0);
    check("rst_wfull", bus.wfull, 0);
    check("rst_afull", bus.walmost_full, 0);
    check("rst_ovf",   bus.woverflow, 0);
    check("rst_waddr", bus.waddr, 0);
    bus.wr_en = 1'b1;
    #1;
    check("rst_wclken_follows_wr_en", bus.wclken, 1);
    bus.wr_en = 1'b0;
    step();
    check("rst_hold_wlevel", bus.wlevel, 0);

    @(negedge clk);
    rst = 1'b1;
    step();

    // ---------------- fill test ----------------
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1;
      #1;
      check($sformatf("fill_waddr_%0d", i), bus.waddr, i);
      check($sformatf("fill_wclken_%0d", i), bus.wclken, 1);
      step();
      check($sformatf("fill_wlevel_%0d", i + 1), bus.wlevel, i + 1);
      if (i == 4) check("afull_at_5", bus.walmost_full, 0);
      if (i == 5) check("afull_at_6", bus.walmost_full, 1);
      if (i == 6) check("not_full_at_7", bus.wfull, 0);
    end
    check("fill_wptr", bus.wptr, 4'b1100);
    check("fill_wfull", bus.wfull, 1);
    check("fill_afull", bus.walmost_full, 1);

    // ---------------- overflow test ----------------
    bus.wr_en = 1'b1;
    #1;
    check("ovf_wclken_blocked", bus.wclken, 0);
    step();
    check("ovf_set", bus.woverflow, 1);
    check("ovf_wptr_hold", bus.wptr, 4'b1100);
    check("ovf_wlevel_hold", bus.wlevel, 8);
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b1;
    step();
    check("ovf_cleared", bus.woverflow, 0);
    bus.wr_en = 1'b1;
    step();
    check("ovf_set_wins_over_clr", bus.woverflow, 1);
    bus.wr_en = 1'b0;
    step();
    check("ovf_cleared_again", bus.woverflow, 0);
    bus.ovf_clr = 1'b0;

    // ---------------- drain / wrap test ----------------
    // Each read frees one slot (wfull drops a cycle later), the next write
    // refills it; the write pointer wraps binary 15 -> 0.
    bus.wr_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.rq_wptr_sync = rd_gray[k];
      step();
      check($sformatf("drain_wfull_clr_%0d", k), bus.wfull, 0);
      check($sformatf("drain_wlevel7_%0d", k), bus.wlevel, 7);
      step();
      check($sformatf("drain_wfull_set_%0d", k), bus.wfull, 1);
      check($sformatf("drain_wptr_%0d", k), bus.wptr, wr_gray[k]);
    end
    check("wrap_wlevel", bus.wlevel, 8);

    // One more read after the wrap: no false full.
    bus.wr_en        = 1'b0;
    bus.ovf_clr      = 1'b1;
    bus.rq_wptr_sync = 4'b1101;
    step();
    bus.ovf_clr = 1'b0;
    check("wrap_no_false_full", bus.wfull, 0);
    check("wrap_wlevel7", bus.wlevel, 7);
    check("wrap_ovf_cleared", bus.woverflow, 0);
    bus.rq_wptr_sync = 4'b1111;
    step();
    bus.rq_wptr_sync = 4'b1110;
    step();
    check("pre_rst_wlevel5", bus.wlevel, 5);
    check("pre_rst_afull", bus.walmost_full, 0);

    // ---------------- asynchronous reset test ----------------
    #2;
    rst = 1'b0;
    bus.rq_wptr_sync = '0;
    #1;
    check("arst_wptr", bus.wptr, 0);
    check("arst_wlevel", bus.wlevel, 0);
    check("arst_waddr", bus.waddr, 0);
    check("arst_wfull", bus.wfull, 0);
    check("arst_afull", bus.walmost_full, 0);
    check("arst_ovf", bus.woverflow, 0);
    step();
    @(negedge clk);
    rst       = 1'b1;
    bus.wr_en = 1'b1;
    #1;
    check("post_rst_waddr", bus.waddr, 0);
    check("post_rst_wclken", bus.wclken, 1);
    @(posedge clk);
    #1;
    check("post_rst_wlevel", bus.wlevel, 1);
    check("post_rst_wptr", bus.wptr, 4'b0001);

    // ---------------- simultaneous write + read ----------------
    step();
    step();
    step();
    check("sim_pre_wlevel4", bus.wlevel, 4);
    check("sim_pre_wptr", bus.wptr, 4'b0110);
    bus.rq_wptr_sync = 4'b0001;
    step();
    check("sim_wlevel4", bus.wlevel, 4);
    check("sim_wptr", bus.wptr, 4'b0111);

    // Read advance alone lowers the level.
    bus.wr_en        = 1'b0;
    bus.rq_wptr_sync = 4'b0011;
    step();
    check("read_only_wlevel3", bus.wlevel, 3);
    check("read_only_wptr_hold", bus.wptr, 4'b0111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: FIFO memory address width; depth DEPTH = 2**ADDR_BITS; pointers are ADDR_BITS+1 bits wide.
REQ-002 SHALL have parameter AFULL_THRESH, default 2: almost-full margin in entries, legal range 1..DEPTH-1.
REQ-003 SHALL have port clk, input, 1 bit: write-domain clock; the block has one clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write request from the producer.
REQ-006 SHALL have port rq_wptr_sync, input, ADDR_BITS+1 bits: Gray-coded read pointer, already passed through the 2-flip-flop synchronizer into the clk domain.
REQ-007 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-008 SHALL have port waddr, output, ADDR_BITS bits: memory write address.
REQ-009 SHALL have port wclken, output, 1 bit: memory write enable, combinational.
REQ-010 SHALL have port wptr, output, ADDR_BITS+1 bits: registered Gray write pointer, sent to the read-side synchronizer.
REQ-011 SHALL have port wfull, output, 1 bit: registered full flag.
REQ-012 SHALL have port walmost_full, output, 1 bit: registered almost-full flag.
REQ-013 SHALL have port wlevel, output, ADDR_BITS+1 bits: registered fill level, range 0..DEPTH.
REQ-014 SHALL have port woverflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-015 SHALL keep a binary pointer wbin (ADDR_BITS+1 bits) and a Gray pointer wptr, both registered.
REQ-016 SHALL define an accepted write as accept = wr_en & ~wfull.
REQ-017 SHALL drive wclken = accept combinationally, and SHALL drive waddr = wbin[ADDR_BITS-1:0].
REQ-018 SHALL compute wbin_next = wbin + accept, mod 2**(ADDR_BITS+1); wrap from all-ones to zero is silent.
REQ-019 SHALL compute wgray_next = (wbin_next >> 1) ^ wbin_next, and SHALL register wbin <= wbin_next and wptr <= wgray_next every cycle.
REQ-020 SHALL register wfull <= (wgray_next == {~rq_wptr_sync[ADDR_BITS:ADDR_BITS-1], rq_wptr_sync[ADDR_BITS-2:0]}).
REQ-021 As a result of REQ-020, wfull SHALL assert on the cycle after the DEPTH-th unread write is accepted.
REQ-022 SHALL convert rq_wptr_sync to binary rbin by a prefix XOR from the MSB down.
REQ-023 SHALL register wlevel <= wbin_next - rbin, mod 2**(ADDR_BITS+1).
REQ-024 SHALL register walmost_full <= (wbin_next - rbin) >= DEPTH - AFULL_THRESH, and SHALL therefore also assert when full.
REQ-025 wr_en while wfull SHALL not write memory, SHALL not advance any pointer, and SHALL set woverflow on the next edge.
REQ-026 woverflow SHALL stay set until ovf_clr is sampled high; if the set and clear conditions coincide, the set SHALL win.
REQ-027 A read-pointer advance (a change in rq_wptr_sync) SHALL deassert wfull and lower wlevel one cycle later; no write accept is needed.
REQ-028 Simultaneous accept and read-pointer change SHALL yield wlevel = old level + 1 - reads seen, with no special casing.
REQ-029 The block SHALL contain no combinational path from rq_wptr_sync to any output.

Reset
REQ-030 While rst is low, wbin, wptr and wlevel SHALL be 0, and wfull, walmost_full and woverflow SHALL be 0, regardless of clk.
REQ-031 Because wbin resets to 0, waddr SHALL be 0 during reset, and wclken SHALL be wr_en.
REQ-032 rst asserted mid-operation SHALL clear all state asynchronously, with no partial write completing afterwards.
REQ-033 After rst deasserts, the first accepted write SHALL be at the first rising clk edge with rst high.

Verification (ADDR_BITS=3, AFULL_THRESH=2, rq_wptr_sync=0 unless stated)
REQ-034 Fill test: wr_en high for 8 cycles -> waddr 0..7, wclken high 8 cycles, wptr=4'b1100, wlevel=8, wfull=1 on cycle after 8th write.
REQ-035 Almost-full test: 6 accepted writes -> walmost_full=1 with wlevel=6; after 5 writes walmost_full=0.
REQ-036 Overflow test: when full, wr_en=1 for 1 cycle -> wclken=0, wptr unchanged, woverflow=1; ovf_clr pulse -> woverflow=0; ovf_clr together with a write while full -> woverflow stays 1.
REQ-037 Drain/wrap test: when full, step rq_wptr_sync through Gray 0001,0011,...,1100 while writing -> wfull clears one cycle after each read; wbin wraps 15->0 with wptr 4'b1000 -> 4'b0000; no false full.
REQ-038 Reset test: rst low at wlevel=5 -> all outputs 0 immediately without a clk edge; after release, the first write goes to waddr=0.
REQ-039 Simultaneous test: at wlevel=4, accept plus one-step read advance in the same cycle -> wlevel=4 next cycle.
